// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the reflector state encoding.
package eth_pkg;

  localparam int MAC_HDR_BYTES = 12;
  localparam int DST_OFFSET    = 0;
  localparam int SRC_OFFSET    = 6;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    EMIT,
    FORWARD,
    DISCARD
  } state_t;

endpackage

// File: rtl/counter.sv
// Free-running event counter; increments once per cycle while enable is high, wraps.
module counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_sel,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/packet_reflector.sv
// Pulls frames from the rx FIFO, reflects those addressed to this node with the
// MAC header rewritten (dst <- received src, src <- own), and drops the rest.
//
// state   | meaning
// IDLE    | waiting for a frame; samples enable
// HEADER  | capturing bytes 0-11 into the header register
// EMIT    | writing the rewritten 12-byte header to tx
// FORWARD | copying payload bytes rx -> tx
// DISCARD | draining a rejected frame up to rx_last
module packet_reflector
  import eth_pkg::*;
#(
  parameter int COUNT_WIDTH      = 32,
  parameter bit ACCEPT_BROADCAST = 1'b1
) (
  input  logic                   clk_sel,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [47:0]            mac_address,
  input  logic [7:0]             rx_data,
  input  logic                   rx_last,
  input  logic                   rx_empty,
  output logic                   rx_read,
  output logic [7:0]             tx_data,
  output logic                   tx_last,
  output logic                   tx_write,
  input  logic                   tx_full,
  output logic [COUNT_WIDTH-1:0] frames_reflected,
  output logic [COUNT_WIDTH-1:0] frames_dropped
);

  state_t      state;
  logic [3:0]  hdr_idx;
  logic [3:0]  emit_idx;
  logic [7:0]  hdr_mem [MAC_HDR_BYTES];
  logic        hdr_last;
  logic [95:0] emit_shift;
  logic [47:0] dst_mac;
  logic        hdr_end;
  logic        emit_end;
  logic        match;
  logic        reflect_pulse;
  logic        drop_pulse;

  assign dst_mac = {hdr_mem[DST_OFFSET],     hdr_mem[DST_OFFSET + 1],
                    hdr_mem[DST_OFFSET + 2], hdr_mem[DST_OFFSET + 3],
                    hdr_mem[DST_OFFSET + 4], hdr_mem[DST_OFFSET + 5]};
  assign match    = (dst_mac == mac_address) ||
                    (ACCEPT_BROADCAST && (dst_mac == BROADCAST_MAC));
  assign hdr_end  = (hdr_idx == 4'(MAC_HDR_BYTES - 1));
  assign emit_end = (emit_idx == 4'(MAC_HDR_BYTES - 1));

  assign rx_read = !rx_empty && ((state == HEADER) || (state == DISCARD) ||
                                 ((state == FORWARD) && !tx_full));

  assign reflect_pulse = ((state == EMIT) && !tx_full && emit_end && hdr_last) ||
                         ((state == FORWARD) && rx_read && rx_last);
  assign drop_pulse    = ((state == HEADER) && rx_read && rx_last && (!hdr_end || !match)) ||
                         ((state == DISCARD) && rx_read && rx_last);

  always_ff @(posedge clk_sel or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hdr_idx    <= '0;
      emit_idx   <= '0;
      hdr_last   <= 1'b0;
      emit_shift <= '0;
      tx_data    <= '0;
      tx_last    <= 1'b0;
      tx_write   <= 1'b0;
      for (int i = 0; i < MAC_HDR_BYTES; i++) hdr_mem[i] <= '0;
    end else begin
      tx_write <= 1'b0;
      tx_last  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_empty) begin
            hdr_idx <= '0;
            state   <= enable ? HEADER : DISCARD;
          end
        end
        HEADER: begin
          if (rx_read) begin
            hdr_mem[hdr_idx] <= rx_data;
            hdr_idx          <= hdr_idx + 4'd1;
            if (!hdr_end) begin
              if (rx_last) state <= IDLE;
            end else if (match) begin
              // byte 11 is still on rx_data, so splice it in directly
              hdr_last   <= rx_last;
              emit_idx   <= '0;
              emit_shift <= {hdr_mem[SRC_OFFSET],     hdr_mem[SRC_OFFSET + 1],
                             hdr_mem[SRC_OFFSET + 2], hdr_mem[SRC_OFFSET + 3],
                             hdr_mem[SRC_OFFSET + 4], rx_data, mac_address};
              state      <= EMIT;
            end else begin
              state <= rx_last ? IDLE : DISCARD;
            end
          end
        end
        EMIT: begin
          if (!tx_full) begin
            tx_write   <= 1'b1;
            tx_data    <= emit_shift[95:88];
            emit_shift <= {emit_shift[87:0], 8'h00};
            emit_idx   <= emit_idx + 4'd1;
            if (emit_end) begin
              tx_last <= hdr_last;
              state   <= hdr_last ? IDLE : FORWARD;
            end
          end
        end
        FORWARD: begin
          if (rx_read) begin
            tx_write <= 1'b1;
            tx_data  <= rx_data;
            tx_last  <= rx_last;
            if (rx_last) state <= IDLE;
          end
        end
        DISCARD: begin
          if (rx_read && rx_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  counter #(.WIDTH(COUNT_WIDTH)) u_reflected (
    .clk_sel (clk_sel),
    .rst     (rst),
    .enable  (reflect_pulse),
    .count   (frames_reflected)
  );

  counter #(.WIDTH(COUNT_WIDTH)) u_dropped (
    .clk_sel (clk_sel),
    .rst     (rst),
    .enable  (drop_pulse),
    .count   (frames_dropped)
  );

endmodule

// File: tb/tb_packet_reflector.sv
// Scoreboard bench for packet_reflector: an rx FIFO model feeds frames, expected
// tx bytes are queued as frames are built and popped as the DUT writes them.
module tb_packet_reflector;

  localparam logic [47:0] OWN   = 48'h0200_0000_0105;
  localparam logic [47:0] PEER  = 48'h0200_0000_0100;
  localparam logic [47:0] OTHER = 48'h0200_0000_0109;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic        clk_sel = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [47:0] mac_address = OWN;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_last = 1'b0;
  logic        rx_empty = 1'b1;
  logic        rx_read;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_write;
  logic        tx_full = 1'b0;
  logic [31:0] frames_reflected;
  logic [31:0] frames_dropped;

  // second instance with broadcast acceptance disabled, own stimulus
  logic [7:0]  rx1_data = 8'h00;
  logic        rx1_last = 1'b0;
  logic        rx1_empty = 1'b1;
  logic        rx1_read;
  logic [7:0]  tx1_data;
  logic        tx1_last;
  logic        tx1_write;
  logic [31:0] reflected1;
  logic [31:0] dropped1;

  packet_reflector #(.COUNT_WIDTH(32), .ACCEPT_BROADCAST(1'b1)) dut (
    .clk_sel(clk_sel), .rst(rst), .enable(enable), .mac_address(mac_address),
    .rx_data(rx_data), .rx_last(rx_last), .rx_empty(rx_empty), .rx_read(rx_read),
    .tx_data(tx_data), .tx_last(tx_last), .tx_write(tx_write), .tx_full(tx_full),
    .frames_reflected(frames_reflected), .frames_dropped(frames_dropped)
  );

  packet_reflector #(.COUNT_WIDTH(32), .ACCEPT_BROADCAST(1'b0)) dut_nobc (
    .clk_sel(clk_sel), .rst(rst), .enable(1'b1), .mac_address(mac_address),
    .rx_data(rx1_data), .rx_last(rx1_last), .rx_empty(rx1_empty), .rx_read(rx1_read),
    .tx_data(tx1_data), .tx_last(tx1_last), .tx_write(tx1_write), .tx_full(1'b0),
    .frames_reflected(reflected1), .frames_dropped(dropped1)
  );

  always #4 clk_sel = ~clk_sel;

  logic [8:0] rxq[$];
  logic [8:0] expq[$];
  logic [8:0] mon_exp;
  int  n_vec = 0;
  int  n_err = 0;
  int  exp_refl = 0;
  int  exp_drop = 0;
  int  popped = 0;
  int  cyc = 0;
  bit  gap_mode = 0;
  bit  full_mode = 0;
  bit  pop_pending = 0;
  bit  full_prev = 0;

  always @(negedge clk_sel) pop_pending = rx_read;

  // rx FIFO model (first-word-fall-through) and tx_full pattern
  always @(posedge clk_sel) begin
    #1;
    if (pop_pending && rxq.size() > 0) begin
      void'(rxq.pop_front());
      popped++;
    end
    pop_pending = 0;
    cyc++;
    tx_full  = full_mode ? (((cyc / 3) % 2) == 1) : 1'b0;
    rx_empty = (rxq.size() == 0) || (gap_mode && ($urandom_range(0, 3) == 0));
    rx_data  = (rxq.size() > 0) ? rxq[0][7:0] : 8'h00;
    rx_last  = (rxq.size() > 0) ? rxq[0][8] : 1'b0;
  end

  always @(negedge clk_sel) begin
    if (!rst && tx_write) begin
      n_vec++;
      if (full_prev) begin
        n_err++;
        $display("FAIL tx_overflow: write with tx_full high the cycle before, required no write");
      end
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got data=%h last=%b, required no write", tx_data, tx_last);
      end else begin
        mon_exp = expq.pop_front();
        if ({tx_last, tx_data} !== mon_exp) begin
          n_err++;
          $display("FAIL tx_byte: got last=%b data=%h, required last=%b data=%h",
                   tx_last, tx_data, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
    full_prev = tx_full;
  end

  task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input int len);
    logic [7:0] b;
    logic [7:0] eb;
    bit m;
    m = enable && (len >= 12) && ((dst == mac_address) || (dst == BCAST));
    for (int i = 0; i < len; i++) begin
      if (i < 6)       b = dst[8*(5-i) +: 8];
      else if (i < 12) b = src[8*(11-i) +: 8];
      else             b = 8'(i * 7 + 3);
      rxq.push_back({(i == len - 1), b});
      if (m) begin
        if (i < 6)       eb = src[8*(5-i) +: 8];
        else if (i < 12) eb = mac_address[8*(11-i) +: 8];
        else             eb = b;
        expq.push_back({(i == len - 1), eb});
      end
    end
    if (m) exp_refl++;
    else   exp_drop++;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((rxq.size() > 0 || expq.size() > 0) && t < 5000) begin
      @(posedge clk_sel);
      t++;
    end
    repeat (4) @(posedge clk_sel);
    n_vec++;
    if (t >= 5000) begin
      n_err++;
      $display("FAIL %s_timeout: rx left=%0d tx expected left=%0d, required 0", name, rxq.size(), expq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sel);
    n_vec += 5;
    if (tx_write !== 1'b0) begin n_err++; $display("FAIL reset_tx_write: got %b, required 0", tx_write); end
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    if (tx_last !== 1'b0) begin n_err++; $display("FAIL reset_tx_last: got %b, required 0", tx_last); end
    if (frames_reflected !== 32'd0) begin n_err++; $display("FAIL reset_reflected: got %0d, required 0", frames_reflected); end
    if (frames_dropped !== 32'd0) begin n_err++; $display("FAIL reset_dropped: got %0d, required 0", frames_dropped); end
    rst = 1'b0;
    repeat (2) @(posedge clk_sel);
  endtask

  task automatic test_reflect();
    push_frame(OWN, PEER, 64);
    wait_drain("reflect");
    @(negedge clk_sel);
    n_vec += 2;
    if (frames_reflected !== 32'(exp_refl)) begin n_err++; $display("FAIL reflect_count: got %0d, required %0d", frames_reflected, exp_refl); end
    if (frames_dropped !== 32'(exp_drop)) begin n_err++; $display("FAIL reflect_dropped: got %0d, required %0d", frames_dropped, exp_drop); end
  endtask

  task automatic test_broadcast();
    push_frame(BCAST, PEER, 64);
    wait_drain("broadcast");
    @(negedge clk_sel);
    n_vec++;
    if (frames_reflected !== 32'(exp_refl)) begin n_err++; $display("FAIL bcast_reflected: got %0d, required %0d", frames_reflected, exp_refl); end
  endtask

  task automatic test_no_broadcast();
    logic [8:0] f1 [64];
    int idx = 0;
    int writes = 0;
    bit pop1;
    logic [47:0] src = PEER;
    for (int i = 0; i < 64; i++) begin
      if (i < 6)       f1[i] = {1'b0, 8'hFF};
      else if (i < 12) f1[i] = {1'b0, src[8*(11-i) +: 8]};
      else             f1[i] = {(i == 63), 8'(i)};
    end
    for (int c = 0; c < 200 && idx < 64; c++) begin
      rx1_data  = f1[idx][7:0];
      rx1_last  = f1[idx][8];
      rx1_empty = 1'b0;
      @(negedge clk_sel);
      pop1 = rx1_read;
      if (tx1_write) writes++;
      @(posedge clk_sel);
      #1;
      if (pop1) idx++;
    end
    rx1_empty = 1'b1;
    repeat (4) begin
      @(negedge clk_sel);
      if (tx1_write) writes++;
    end
    n_vec += 4;
    if (idx !== 64) begin n_err++; $display("FAIL nobc_popped: got %0d, required 64", idx); end
    if (writes !== 0) begin n_err++; $display("FAIL nobc_writes: got %0d, required 0", writes); end
    if (dropped1 !== 32'd1) begin n_err++; $display("FAIL nobc_dropped: got %0d, required 1", dropped1); end
    if (reflected1 !== 32'd0) begin n_err++; $display("FAIL nobc_reflected: got %0d, required 0", reflected1); end
  endtask

  task automatic test_mismatch();
    int p0 = popped;
    push_frame(OTHER, PEER, 100);
    push_frame(OWN, PEER, 64);
    wait_drain("mismatch");
    @(negedge clk_sel);
    n_vec += 3;
    if (popped - p0 !== 164) begin n_err++; $display("FAIL mismatch_popped: got %0d, required 164", popped - p0); end
    if (frames_dropped !== 32'(exp_drop)) begin n_err++; $display("FAIL mismatch_dropped: got %0d, required %0d", frames_dropped, exp_drop); end
    if (frames_reflected !== 32'(exp_refl)) begin n_err++; $display("FAIL mismatch_reflected: got %0d, required %0d", frames_reflected, exp_refl); end
  endtask

  task automatic test_runt();
    push_frame(OWN, PEER, 8);
    push_frame(OWN, PEER, 12);
    wait_drain("runt");
    @(negedge clk_sel);
    n_vec += 2;
    if (frames_dropped !== 32'(exp_drop)) begin n_err++; $display("FAIL runt_dropped: got %0d, required %0d", frames_dropped, exp_drop); end
    if (frames_reflected !== 32'(exp_refl)) begin n_err++; $display("FAIL runt_reflected: got %0d, required %0d", frames_reflected, exp_refl); end
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    push_frame(OWN, PEER, 20);
    wait_drain("enable_off");
    enable = 1'b1;
    @(negedge clk_sel);
    n_vec += 2;
    if (frames_dropped !== 32'(exp_drop)) begin n_err++; $display("FAIL enoff_dropped: got %0d, required %0d", frames_dropped, exp_drop); end
    if (frames_reflected !== 32'(exp_refl)) begin n_err++; $display("FAIL enoff_reflected: got %0d, required %0d", frames_reflected, exp_refl); end
  endtask

  task automatic test_back_pressure();
    full_mode = 1;
    gap_mode  = 1;
    push_frame(OWN, PEER, 64);
    push_frame(OWN, PEER, 40);
    wait_drain("backpressure");
    full_mode = 0;
    gap_mode  = 0;
    repeat (2) @(posedge clk_sel);
    @(negedge clk_sel);
    n_vec++;
    if (frames_reflected !== 32'(exp_refl)) begin n_err++; $display("FAIL bp_reflected: got %0d, required %0d", frames_reflected, exp_refl); end
  endtask

  task automatic test_reset_mid();
    int p0 = popped;
    int t = 0;
    push_frame(OWN, PEER, 64);
    while (popped - p0 < 31 && t < 500) begin
      @(posedge clk_sel);
      t++;
    end
    n_vec++;
    if (t >= 500) begin n_err++; $display("FAIL rstmid_timeout: popped %0d, required 31", popped - p0); end
    @(negedge clk_sel);
    rst = 1'b1;
    @(posedge clk_sel);
    @(negedge clk_sel);
    n_vec += 5;
    if (tx_write !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_write: got %b, required 0", tx_write); end
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_tx_data: got %h, required 00", tx_data); end
    if (tx_last !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_last: got %b, required 0", tx_last); end
    if (frames_reflected !== 32'd0) begin n_err++; $display("FAIL rstmid_reflected: got %0d, required 0", frames_reflected); end
    if (frames_dropped !== 32'd0) begin n_err++; $display("FAIL rstmid_dropped: got %0d, required 0", frames_dropped); end
    rxq.delete();
    expq.delete();
    exp_refl = 0;
    exp_drop = 0;
    @(negedge clk_sel);
    rst = 1'b0;
    repeat (2) @(posedge clk_sel);
    push_frame(OWN, PEER, 30);
    wait_drain("after_reset");
    @(negedge clk_sel);
    n_vec += 2;
    if (frames_reflected !== 32'd1) begin n_err++; $display("FAIL rstmid_next_reflected: got %0d, required 1", frames_reflected); end
    if (frames_dropped !== 32'd0) begin n_err++; $display("FAIL rstmid_next_dropped: got %0d, required 0", frames_dropped); end
  endtask

  initial begin
    repeat (3) @(posedge clk_sel);
    test_reset();
    test_reflect();
    test_broadcast();
    test_no_broadcast();
    test_mismatch();
    test_runt();
    test_enable_off();
    test_back_pressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_reflector.md
Name: packet_reflector

Overview:
Responder-side traffic engine for the retransmitter node. It pulls received frames from the rx FIFO and checks the destination MAC against the node address (or broadcast). Matching frames are written back to the tx FIFO with the MAC header rewritten: new destination = received source, new source = own address. Non-matching or runt frames are discarded. Payload bytes, including the measurer's timestamp, pass through untouched so the originator can compute round-trip latency.

Parameters:
COUNT_WIDTH, 32, width of the reflected/dropped frame counters
ACCEPT_BROADCAST, 1, 1 = destination FF:FF:FF:FF:FF:FF is treated as a match

Ports:
clk_sel  in  1  system clock, 125 MHz
rst  in  1  reset, asynchronous, active-high
enable  in  1  reflection enable, sampled in IDLE only
mac_address  in  48  own MAC address, static during operation
rx_data  in  8  rx FIFO byte, first-word-fall-through, valid while !rx_empty
rx_last  in  1  rx FIFO sideband, high on the final byte of a frame
rx_empty  in  1  rx FIFO empty
rx_read  out  1  rx FIFO pop, combinational
tx_data  out  8  tx FIFO write byte, registered
tx_last  out  1  tx FIFO sideband end-of-frame, registered
tx_write  out  1  tx FIFO write strobe, registered
tx_full  in  1  tx FIFO programmable-full, asserted with at least 2 free entries
frames_reflected  out  COUNT_WIDTH  count of frames reflected
frames_dropped  out  COUNT_WIDTH  count of frames discarded

Behaviour:
- Reset: state = IDLE; tx_data = 0, tx_last = 0, tx_write = 0; both counters = 0; header buffer cleared. Reset mid-frame abandons the frame. The FIFOs share rst, so no partial frame survives.
- Frame layout: bytes 0-5 are the destination MAC (MSB first), bytes 6-11 are the source MAC, bytes 12 and up are the payload.
- rx_read is high only when !rx_empty and the current state consumes input. A byte is consumed on every clk_sel edge where rx_read = 1.
- IDLE: if rx_empty, stay in IDLE. Otherwise go to HEADER if enable = 1, or to DISCARD if enable = 0. IDLE reads nothing.
- HEADER:
  - rx_read = !rx_empty.
  - Store bytes 0-11 into a 12-byte header register, indexed by a 4-bit counter.
  - rx_last seen on byte index < 11: runt frame. frames_dropped += 1, go to IDLE.
  - On byte 11: match = (dst == mac_address) or (ACCEPT_BROADCAST and dst == all-ones).
  - Match: go to EMIT, and latch hdr_last = rx_last of byte 11.
  - No match: if rx_last is set, frames_dropped += 1 and go to IDLE; otherwise go to DISCARD.
- EMIT:
  - rx_read = 0.
  - On each cycle with !tx_full, write one byte: output bytes 0-5 = stored source MAC, bytes 6-11 = mac_address.
  - After byte 11 is written: if hdr_last, tx_last = 1 on that byte, frames_reflected += 1, go to IDLE; otherwise go to FORWARD.
- FORWARD:
  - rx_read = !rx_empty and !tx_full.
  - On each read, on the next edge: tx_write = 1, tx_data = rx_data, tx_last = rx_last.
  - A read with rx_last: frames_reflected += 1, go to IDLE.
- DISCARD: rx_read = !rx_empty. A read with rx_last: frames_dropped += 1, go to IDLE.
- Write latency: tx_write rises one cycle after the EMIT/FORWARD decision. tx_write is 0 in all other cycles. The 2-entry tx_full slack covers the registered output.
- Throughput: 1 byte/cycle in FORWARD with no stalls. Per-frame overhead is 12 header-read cycles plus 12 emit cycles plus 1 IDLE cycle.
- Counters wrap modulo 2^COUNT_WIDTH. A counter increments at most once per cycle; at most one counter increments per cycle.
- A change of mac_address mid-frame is undefined. enable changes take effect at the next IDLE.
- rx_empty asserted mid-frame: stall in place, keeping the counter and state.

Decomposition:
- Shared package eth_pkg, holding:
  - localparams MAC_HDR_BYTES = 12, DST_OFFSET = 0, SRC_OFFSET = 6, BROADCAST_MAC = 48'hFFFF_FFFF_FFFF
  - the state encoding IDLE/HEADER/EMIT/FORWARD/DISCARD
- Counters reuse the existing counter module, two instances with WIDTH = COUNT_WIDTH; enable is driven by the reflect/drop pulse.
- No other sub-module; the header register and FSM stay in this module.

Test Plan:
- 64-byte frame, dst = 02:00:00:00:01:05 = mac_address, src = 02:00:00:00:01:00 -> 64 tx bytes with dst = 02:00:00:00:01:00, src = 02:00:00:00:01:05, payload identical, tx_last on byte 63 only, frames_reflected = 1.
- Broadcast dst frame with ACCEPT_BROADCAST = 1 -> reflected; same frame with ACCEPT_BROADCAST = 0 -> no tx_write, frames_dropped = 1.
- Unicast dst 02:00:00:00:01:09 (mismatch), 100 bytes -> all 100 bytes popped, zero tx writes, frames_dropped = 1. Next matching frame reflects correctly.
- 8-byte runt, then an exact 12-byte frame -> runt dropped (dropped = 1); the 12-byte frame is emitted as header only with tx_last on byte 11, reflected = 1.
- Matching 64-byte frame with tx_full toggled every 3 cycles and rx_empty gaps mid-payload -> output byte sequence unchanged, no FIFO overflow, no duplicated or skipped bytes.
- Assert rst during FORWARD at byte 30 -> all outputs 0 the next cycle, state IDLE, counters 0. The next frame is processed normally.
